// File: rtl/pong_game_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_ctrl_if
// Brief    : Ball/paddle positions in, ball controls and score board out.
//            The master side feeds positions, the slave is the game controller.
// Revision : 1.0  initial release
// ============================================================================
interface pong_game_ctrl_if;
  logic [9:0] HBall;
  logic [9:0] VBall;
  logic [9:0] P1_V;
  logic [9:0] P2_V;
  logic       Game_Start;
  logic [1:0] hit;
  logic [3:0] P1_score;
  logic [3:0] P2_score;
  logic [1:0] Winner;
  logic [2:0] state;

  modport master (
    output HBall, VBall, P1_V, P2_V,
    input  Game_Start, hit, P1_score, P2_score, Winner, state
  );

  modport slave (
    input  HBall, VBall, P1_V, P2_V,
    output Game_Start, hit, P1_score, P2_score, Winner, state
  );
endinterface
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_ctrl
// Brief    : Pong game sequencer. Drives the ball's Game_Start/hit controls,
//            detects wall/paddle bounces and misses, keeps scores, enforces
//            the serve delay and the end of the match.
// Revision : 1.0  initial release
// ============================================================================
module pong_game_ctrl #(
  parameter int ACTIVE_WIDTH  = 640,
  parameter int ACTIVE_HEIGHT = 480,
  parameter int BALL_WIDTH    = 20,
  parameter int BALL_HEIGHT   = 20,
  parameter int PADDLE_WIDTH  = 10,
  parameter int PADDLE_HEIGHT = 80,
  parameter int P1_X          = 20,
  parameter int P2_X          = 610,
  parameter int SERVE_DELAY   = 4_000_000,
  parameter int WIN_SCORE     = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_btn,
  pong_game_ctrl_if.slave bus
);

  localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(SERVE_DELAY - 1);
  localparam logic [10:0] c_ball_w     = 11'(BALL_WIDTH);
  localparam logic [10:0] c_ball_h     = 11'(BALL_HEIGHT);
  localparam logic [10:0] c_pad_h      = 11'(PADDLE_HEIGHT);
  localparam logic [10:0] c_p1_x       = 11'(P1_X);
  localparam logic [10:0] c_p2_x       = 11'(P2_X);
  localparam logic [10:0] c_p1_x_far   = 11'(P1_X + PADDLE_WIDTH);
  localparam logic [10:0] c_p2_x_far   = 11'(P2_X + PADDLE_WIDTH);
  localparam logic [10:0] c_right_lim  = 11'(ACTIVE_WIDTH - 1);
  localparam logic [10:0] c_bottom_lim = 11'(ACTIVE_HEIGHT - 1);
  localparam logic [3:0]  c_win        = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync_d;
  logic             w_start_edge;
  logic [CNT_W-1:0] r_serve_cnt;
  logic [1:0]       r_hit;
  logic [3:0]       r_p1_score;
  logic [3:0]       r_p2_score;
  logic [1:0]       r_winner;
  logic             r_p1_scored;

  // Positions widened by one bit so extent sums cannot wrap.
  logic [10:0] w_hb, w_vb, w_p1v, w_p2v;
  logic        w_top, w_bottom, w_p1_ret, w_p2_ret, w_p1_miss, w_p2_miss;
  logic [3:0]  w_p1_inc, w_p2_inc, w_new_score;
  logic        w_win;

  assign w_hb  = {1'b0, bus.HBall};
  assign w_vb  = {1'b0, bus.VBall};
  assign w_p1v = {1'b0, bus.P1_V};
  assign w_p2v = {1'b0, bus.P2_V};

  assign w_start_edge = r_sync2 & ~r_sync_d;

  // Every rule is gated by the current direction so a parked ball does not re-fire.
  assign w_top     = (w_vb == 11'd0) && r_hit[0];
  assign w_bottom  = (w_vb + c_ball_h >= c_bottom_lim) && !r_hit[0];
  assign w_p1_ret  = !r_hit[1] && (w_hb <= c_p1_x_far) && (w_hb + c_ball_w >= c_p1_x) &&
                     (w_vb + c_ball_h >= w_p1v) && (w_vb <= w_p1v + c_pad_h);
  assign w_p2_ret  = r_hit[1] && (w_hb <= c_p2_x_far) && (w_hb + c_ball_w >= c_p2_x) &&
                     (w_vb + c_ball_h >= w_p2v) && (w_vb <= w_p2v + c_pad_h);
  assign w_p1_miss = (w_hb == 11'd0) && !r_hit[1];
  assign w_p2_miss = (w_hb + c_ball_w >= c_right_lim) && r_hit[1];

  // Scores stick at 15 rather than wrapping.
  assign w_p1_inc    = (r_p1_score == 4'hF) ? 4'hF : r_p1_score + 4'd1;
  assign w_p2_inc    = (r_p2_score == 4'hF) ? 4'hF : r_p2_score + 4'd1;
  assign w_new_score = r_p1_scored ? w_p1_inc : w_p2_inc;
  assign w_win       = (w_new_score == c_win);

  // Two-flop synchroniser plus a delay flop for rising-edge detection of the button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= start_btn;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; button edges only matter in IDLE and OVER.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_edge) w_state_nxt = S_SERVE;
      S_SERVE: if (r_serve_cnt == c_cnt_last) w_state_nxt = S_PLAY;
      S_PLAY:  if (w_p1_miss || w_p2_miss) w_state_nxt = S_POINT;
      S_POINT: w_state_nxt = w_win ? S_OVER : S_SERVE;
      S_OVER:  if (w_start_edge) w_state_nxt = S_SERVE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ball direction, serve counter, scores and winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit       <= 2'b10;
      r_p1_score  <= 4'd0;
      r_p2_score  <= 4'd0;
      r_winner    <= 2'b00;
      r_serve_cnt <= '0;
      r_p1_scored <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_serve_cnt <= '0;
            r_hit       <= 2'b10;
          end
        end
        S_SERVE: begin
          r_serve_cnt <= (r_serve_cnt == c_cnt_last) ? '0 : r_serve_cnt + CNT_W'(1);
        end
        S_PLAY: begin
          // Walls act on the vertical bit independently of the horizontal outcome.
          if (w_top)         r_hit[0] <= 1'b0;
          else if (w_bottom) r_hit[0] <= 1'b1;
          if (w_p1_miss || w_p2_miss) begin
            r_p1_scored <= w_p2_miss;
          end else if (w_p1_ret) begin
            r_hit[1] <= 1'b1;
          end else if (w_p2_ret) begin
            r_hit[1] <= 1'b0;
          end
        end
        S_POINT: begin
          // Next serve heads toward whoever conceded.
          if (r_p1_scored) begin
            r_p1_score <= w_p1_inc;
            r_hit      <= 2'b10;
          end else begin
            r_p2_score <= w_p2_inc;
            r_hit      <= 2'b00;
          end
          if (w_win) r_winner <= r_p1_scored ? 2'b01 : 2'b10;
        end
        S_OVER: begin
          if (w_start_edge) begin
            r_p1_score  <= 4'd0;
            r_p2_score  <= 4'd0;
            r_winner    <= 2'b00;
            r_hit       <= 2'b10;
            r_serve_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Game_Start = (r_state == S_PLAY);
  assign bus.hit        = r_hit;
  assign bus.P1_score   = r_p1_score;
  assign bus.P2_score   = r_p2_score;
  assign bus.Winner     = r_winner;
  assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_game_ctrl
// Brief    : Directed plus random bench for pong_game_ctrl with a game-level
//            reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pong_game_ctrl;

  localparam int SD  = 100;
  localparam int WIN = 4;
  localparam int AW  = 640;
  localparam int AH  = 480;
  localparam int BW  = 20;
  localparam int BH  = 20;
  localparam int PW  = 10;
  localparam int PH  = 80;
  localparam int P1X = 20;
  localparam int P2X = 610;

  localparam int ST_IDLE  = 0;
  localparam int ST_SERVE = 1;
  localparam int ST_PLAY  = 2;
  localparam int ST_POINT = 3;
  localparam int ST_OVER  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_btn = 1'b0;
  int   total = 0;
  int   bad = 0;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(
    .ACTIVE_WIDTH (AW),
    .ACTIVE_HEIGHT(AH),
    .BALL_WIDTH   (BW),
    .BALL_HEIGHT  (BH),
    .PADDLE_WIDTH (PW),
    .PADDLE_HEIGHT(PH),
    .P1_X         (P1X),
    .P2_X         (P2X),
    .SERVE_DELAY  (SD),
    .WIN_SCORE    (WIN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_btn(start_btn),
    .bus      (bus)
  );

  always #20 clk = ~clk;

  // Game-level model: phase, direction (right/up), scores, winner, serve clocks.
  int m_state, m_hit, m_p1, m_p2, m_win, m_cnt, m_scorer;
  bit h1, h2, h3;

  task automatic model_reset();
    m_state = ST_IDLE; m_hit = 2; m_p1 = 0; m_p2 = 0; m_win = 0; m_cnt = 0;
    m_scorer = 0; h1 = 0; h2 = 0; h3 = 0;
  endtask

  function automatic bit overlaps(int h, int v, int px, int pv);
    return (h <= px + PW) && (h + BW >= px) && (v + BH >= pv) && (v <= pv + PH);
  endfunction

  task automatic model_step();
    bit stedge, right, up, nr, nu, miss1, miss2;
    int h, v, s;
    if (!rst_n) begin model_reset(); return; end
    stedge = h2 && !h3;
    h3 = h2; h2 = h1; h1 = start_btn;
    h = int'(bus.HBall);
    v = int'(bus.VBall);
    s = 0;
    case (m_state)
      ST_IDLE: if (stedge) begin m_state = ST_SERVE; m_cnt = 0; m_hit = 2; end
      ST_SERVE: begin
        m_cnt++;
        if (m_cnt == SD) begin m_state = ST_PLAY; m_cnt = 0; end
      end
      ST_PLAY: begin
        right = (m_hit / 2) == 1;
        up    = (m_hit % 2) == 1;
        nr = right; nu = up;
        if (v == 0 && up) nu = 0;
        if (v + BH >= AH - 1 && !up) nu = 1;
        miss1 = (h == 0) && !right;
        miss2 = (h + BW >= AW - 1) && right;
        if (miss1 || miss2) begin
          m_state = ST_POINT;
          m_scorer = miss1 ? 2 : 1;
        end else begin
          if (!right && overlaps(h, v, P1X, int'(bus.P1_V))) nr = 1;
          if (right && overlaps(h, v, P2X, int'(bus.P2_V))) nr = 0;
        end
        m_hit = (nr ? 2 : 0) + (nu ? 1 : 0);
      end
      ST_POINT: begin
        if (m_scorer == 1) begin
          m_p1 = (m_p1 < 15) ? m_p1 + 1 : 15; s = m_p1; m_hit = 2;
        end else begin
          m_p2 = (m_p2 < 15) ? m_p2 + 1 : 15; s = m_p2; m_hit = 0;
        end
        if (s == WIN) begin m_state = ST_OVER; m_win = m_scorer; end
        else m_state = ST_SERVE;
      end
      ST_OVER: if (stedge) begin
        m_p1 = 0; m_p2 = 0; m_win = 0; m_hit = 2; m_cnt = 0; m_state = ST_SERVE;
      end
      default: m_state = ST_IDLE;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("state", bus.state, m_state);
    check("game_start", bus.Game_Start, (m_state == ST_PLAY) ? 1 : 0);
    check("hit", bus.hit, m_hit);
    check("p1_score", bus.P1_score, m_p1);
    check("p2_score", bus.P2_score, m_p2);
    check("winner", bus.Winner, m_win);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic set_ball(input int h, input int v);
    bus.HBall = 10'(h);
    bus.VBall = 10'(v);
  endtask

  task automatic wait_state(input int s, input int budget, input string tag);
    int n = 0;
    while (m_state != s && n < budget) begin tick(); n++; end
    check(tag, bus.state, s);
  endtask

  task automatic p1_point();
    set_ball(630, 200); tick();
    set_ball(300, 200); tick();
  endtask

  initial begin
    model_reset();
    set_ball(300, 200);
    bus.P1_V = 10'd200;
    bus.P2_V = 10'd200;

    // Reset values
    repeat (3) tick();
    check("rst_state", bus.state, ST_IDLE);
    check("rst_gs", bus.Game_Start, 0);
    check("rst_hit", bus.hit, 2'b10);
    check("rst_winner", bus.Winner, 0);
    rst_n = 1'b1;

    // Start edge latency and serve delay
    repeat (10) tick();
    start_btn = 1'b1;
    tick(); tick();
    check("start_lat2", bus.state, ST_IDLE);
    tick();
    check("start_lat3", bus.state, ST_SERVE);
    for (int i = 1; i < SD; i++) begin
      if (i == 5)  start_btn = 1'b0;
      if (i == 20) start_btn = 1'b1;
      if (i == 40) start_btn = 1'b0;
      tick();
    end
    check("serve_hold", bus.Game_Start, 0);
    tick();
    check("serve_go", bus.Game_Start, 1);
    check("serve_hit", bus.hit, 2'b10);

    // Bottom then top wall
    set_ball(300, 470); tick(); check("bottom", bus.hit, 2'b11);
    set_ball(300, 5);   tick(); check("near_top", bus.hit, 2'b11);
    set_ball(300, 0);   tick(); check("top", bus.hit, 2'b10);
    tick();                     check("top_hold", bus.hit, 2'b10);

    // Paddle returns
    set_ball(600, 230); tick(); check("p2_ret", bus.hit, 2'b00);
    set_ball(30, 350);  tick(); check("p1_no_overlap", bus.hit, 2'b00);
    set_ball(30, 230);  tick(); check("p1_ret", bus.hit, 2'b10);
    set_ball(600, 230); tick(); check("p2_ret2", bus.hit, 2'b00);
    set_ball(300, 470); tick(); check("bottom2", bus.hit, 2'b01);

    // P1 miss while overlapping the paddle: miss wins
    set_ball(0, 200); tick();
    check("miss_point", bus.state, ST_POINT);
    check("miss_gs", bus.Game_Start, 0);
    set_ball(300, 200); tick();
    check("miss_serve", bus.state, ST_SERVE);
    check("miss_p2", bus.P2_score, 1);
    check("miss_hit", bus.hit, 2'b00);

    // Match end: P1 takes WIN points
    wait_state(ST_PLAY, SD + 5, "to_play1");
    set_ball(30, 230); tick(); check("p1_ret3", bus.hit, 2'b10);
    set_ball(300, 200);
    for (int k = 0; k < WIN; k++) begin
      p1_point();
      if (k < WIN - 1) wait_state(ST_PLAY, SD + 5, "to_play_m");
    end
    check("over_state", bus.state, ST_OVER);
    check("over_p1", bus.P1_score, WIN);
    check("over_winner", bus.Winner, 2'b01);
    check("over_gs", bus.Game_Start, 0);
    repeat (5) tick();
    start_btn = 1'b1;
    repeat (3) tick();
    check("restart_state", bus.state, ST_SERVE);
    check("restart_p1", bus.P1_score, 0);
    check("restart_winner", bus.Winner, 0);
    start_btn = 1'b0;

    // Reset in the middle of play with P1 on 3
    wait_state(ST_PLAY, SD + 5, "to_play2");
    for (int k = 0; k < 3; k++) begin
      p1_point();
      wait_state(ST_PLAY, SD + 5, "to_play_r");
    end
    check("pre_rst_p1", bus.P1_score, 3);
    @(posedge clk);
    model_step();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_state", bus.state, ST_IDLE);
    check("midrst_p1", bus.P1_score, 0);
    check("midrst_gs", bus.Game_Start, 0);
    check("midrst_hit", bus.hit, 2'b10);
    check_all();
    tick(); tick();
    rst_n = 1'b1;

    // Random play against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.HBall = 10'd0;
          1: bus.HBall = 10'(625);
          2: bus.HBall = 10'(30);
          default: bus.HBall = 10'(600);
        endcase
      end else begin
        bus.HBall = 10'($urandom_range(0, AW - 1));
      end
      bus.VBall = 10'($urandom_range(0, AH - 1));
      bus.P1_V  = 10'($urandom_range(0, 400));
      bus.P2_V  = 10'($urandom_range(0, 400));
      if ($urandom_range(0, 63) == 0) start_btn = ~start_btn;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
